// File: rtl/regfile_32x32.sv
// regfile_32x32 -- 2-read / 1-write register file with a post-reset clear sweep.
//
// Register 0 reads as zero and has no storage. After reset the block walks
// registers 1..2^AW-1 one per cycle and zeroes them, holding BUSY high for the
// whole sweep. Writes that arrive during the sweep are discarded and flagged on
// WR_DROP one cycle later. Reads are combinational and include a write-through
// bypass so a same-cycle write to the addressed register is visible at once.
//
// Ports
//   CLK      in   1      clock, all state on rising edge
//   RST      in   1      synchronous active-high reset, highest priority
//   WE       in   1      write enable
//   WA       in   AW     write address
//   WD       in   WIDTH  write data
//   RA1/RA2  in   AW     read addresses
//   RD1/RD2  out  WIDTH  read data (combinational)
//   BUSY     out  1      clear sweep in progress
//   WR_DROP  out  1      one-cycle pulse: previous-cycle write was discarded

// One combinational read port. Instantiated once per read port by the top.
module regfile_rd_port #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic                             busy,
    input  logic                             byp_en,
    input  logic [AW-1:0]                    wa,
    input  logic [WIDTH-1:0]                 wd,
    input  logic [(1<<AW)-1:1][WIDTH-1:0]    mem,
    input  logic [AW-1:0]                    ra,
    output logic [WIDTH-1:0]                 rd
);

    // ra != 0 guards the array select (entry 0 does not exist) and also makes
    // the bypass compare imply wa != 0.
    always_comb begin
        rd = '0;
        if (!busy && ra != '0) begin
            if (byp_en && wa == ra) rd = wd;
            else                    rd = mem[ra];
        end
    end

endmodule

module regfile_32x32 #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [AW-1:0]    RA1,
    input  logic [AW-1:0]    RA2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic             BUSY,
    output logic             WR_DROP
);

    localparam int NREG   = 1 << AW;
    localparam int NUM_RD = 2;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    localparam logic [AW-1:0] CNT_LAST = '1;
    localparam logic [AW-1:0] CNT_INIT = AW'(1);

    logic [0:0]                   state;
    logic [AW-1:0]                cnt;
    logic [NREG-1:1][WIDTH-1:0]   mem;

    logic                         mem_we;
    logic [AW-1:0]                mem_wa;
    logic [WIDTH-1:0]             mem_wd;

    // ------------------------------------------------------------------
    // Control: clear sweep FSM, drop flag
    // ------------------------------------------------------------------
    // cnt stops at CNT_LAST on the final sweep edge instead of wrapping; it is
    // only meaningful in CLEAR and is reloaded by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= CLEAR;
            cnt     <= CNT_INIT;
            WR_DROP <= 1'b0;
        end else if (state == CLEAR) begin
            WR_DROP <= WE;
            if (cnt == CNT_LAST) state <= READY;
            else                 cnt   <= cnt + 1'b1;
        end else begin
            WR_DROP <= 1'b0;
        end
    end

    assign BUSY = (state == CLEAR);

    // ------------------------------------------------------------------
    // Storage write port: sweep clear in CLEAR, user write in READY
    // ------------------------------------------------------------------
    always_comb begin
        mem_we = 1'b0;
        mem_wa = cnt;
        mem_wd = '0;
        if (!RST) begin
            if (state == CLEAR) begin
                mem_we = (cnt != '0);
            end else if (WE && WA != '0) begin
                mem_we = 1'b1;
                mem_wa = WA;
                mem_wd = WD;
            end
        end
    end

    // Storage carries no reset; the sweep is what initialises it.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [NUM_RD-1:0][AW-1:0]    ra_pk;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_pk;
    logic                         byp_en;

    assign ra_pk  = {RA2, RA1};
    assign byp_en = WE && (state == READY);

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_rd_port #(
            .WIDTH (WIDTH),
            .AW    (AW)
        ) u_rd (
            .busy   (BUSY),
            .byp_en (byp_en),
            .wa     (WA),
            .wd     (WD),
            .mem    (mem),
            .ra     (ra_pk[p]),
            .rd     (rd_pk[p])
        );
    end

    assign RD1 = rd_pk[0];
    assign RD2 = rd_pk[1];

endmodule

// File: tb/tb_regfile_32x32.sv
// tb_regfile_32x32 -- directed self-checking bench for regfile_32x32.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// checked after a further settle delay, registered outputs right after the edge.
module tb_regfile_32x32;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             CLK = 1'b0;
    logic             RST;
    logic             WE;
    logic [AW-1:0]    WA;
    logic [WIDTH-1:0] WD;
    logic [AW-1:0]    RA1;
    logic [AW-1:0]    RA2;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic             BUSY;
    logic             WR_DROP;

    int n_chk  = 0;
    int n_pass = 0;

    regfile_32x32 #(.WIDTH(WIDTH), .AW(AW)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .WE      (WE),
        .WA      (WA),
        .WD      (WD),
        .RA1     (RA1),
        .RA2     (RA2),
        .RD1     (RD1),
        .RD2     (RD2),
        .BUSY    (BUSY),
        .WR_DROP (WR_DROP)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        WE = 1'b1; WA = a; WD = d;
        cyc();
        WE = 1'b0;
    endtask

    // One reset edge; returns in the first BUSY cycle with RST released.
    task automatic do_reset();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
    endtask

    // Counts BUSY-high cycles starting from the current cycle (bounded).
    task automatic count_busy(output int n);
        n = 0;
        while (BUSY === 1'b1 && n < 100) begin
            n++;
            cyc();
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            RA1 = AW'(i);
            RA2 = AW'(31 - i);
            #1;
            chk({tag, "_rd1"}, RD1, 32'h0);
            chk({tag, "_rd2"}, RD2, 32'h0);
        end
    endtask

    task automatic fill_index();
        for (int i = 1; i < 32; i++) wr(AW'(i), WIDTH'(i));
    endtask

    int nb;

    initial begin
        RST = 1'b1; WE = 1'b0; WA = '0; WD = '0; RA1 = 5'd3; RA2 = 5'd0;

        // Reset and clear sweep length; reads forced to 0 while busy.
        do_reset();
        chk("rst_busy", {31'b0, BUSY}, 32'd1);
        chk("rst_drop", {31'b0, WR_DROP}, 32'd0);
        #1;
        chk("busy_rd1_zero", RD1, 32'h0);
        count_busy(nb);
        chk("busy_len", nb, 32'd31);
        chk("ready_busy", {31'b0, BUSY}, 32'd0);
        read_all_zero("post_clr");

        // Bypass then stored value.
        WE = 1'b1; WA = 5'd5; WD = 32'hDEADBEEF; RA1 = 5'd5; RA2 = 5'd6;
        #1;
        chk("byp_rd1", RD1, 32'hDEADBEEF);
        chk("byp_rd2_other", RD2, 32'h0);
        cyc();
        WE = 1'b0; RA2 = 5'd5;
        #1;
        chk("stored_rd1", RD1, 32'hDEADBEEF);
        chk("stored_rd2", RD2, 32'hDEADBEEF);

        // Write to register 0 is ignored silently.
        WE = 1'b1; WA = 5'd0; WD = 32'hFFFFFFFF; RA1 = 5'd0; RA2 = 5'd0;
        #1;
        chk("r0_byp_rd1", RD1, 32'h0);
        chk("r0_byp_rd2", RD2, 32'h0);
        cyc();
        WE = 1'b0;
        chk("r0_no_drop", {31'b0, WR_DROP}, 32'd0);
        #1;
        chk("r0_rd1", RD1, 32'h0);
        chk("r0_rd2", RD2, 32'h0);
        RA1 = 5'd5;
        #1;
        chk("r5_kept", RD1, 32'hDEADBEEF);

        // Fill 1..31, read back, reset during READY.
        fill_index();
        for (int i = 1; i < 32; i++) begin
            RA1 = AW'(i);
            RA2 = AW'(32 - i);
            #1;
            chk("fill_rd1", RD1, 32'(i));
            chk("fill_rd2", RD2, 32'(32 - i));
        end
        do_reset();
        chk("rst2_busy", {31'b0, BUSY}, 32'd1);
        count_busy(nb);
        chk("busy_len2", nb, 32'd31);
        read_all_zero("post_rst2");

        // Dropped writes: 3rd busy cycle (reg 7) and last busy cycle (reg 5).
        do_reset();
        for (int c = 1; c <= 34; c++) begin
            WE = 1'b0;
            if (c == 3)  begin WE = 1'b1; WA = 5'd7; WD = 32'h12345678; end
            if (c == 31) begin WE = 1'b1; WA = 5'd5; WD = 32'hA5A5A5A5; end
            chk($sformatf("drop_busy_c%0d", c), {31'b0, BUSY}, (c <= 31) ? 32'd1 : 32'd0);
            chk($sformatf("drop_flag_c%0d", c), {31'b0, WR_DROP},
                (c == 4 || c == 32) ? 32'd1 : 32'd0);
            if (c < 34) cyc();
        end
        WE = 1'b0; RA1 = 5'd7; RA2 = 5'd5;
        #1;
        chk("drop_r7", RD1, 32'h0);
        chk("drop_r5", RD2, 32'h0);

        // Reset again mid-sweep at CNT=10 with registers holding data.
        fill_index();
        do_reset();
        for (int c = 1; c < 10; c++) cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        chk("mid_rst_busy", {31'b0, BUSY}, 32'd1);
        count_busy(nb);
        chk("busy_len_mid", nb, 32'd31);
        read_all_zero("post_mid");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Hard time limit so the bench never hangs.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
